// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an on-chip word array: independent write and read burst engines with a
// programmable pre-data delay, out-of-range and wlast checking, and a prefetching registered read.
module axi_mem_responder #(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned ID_WIDTH     = 4,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter int unsigned RESP_DELAY   = 4
) (
    input  logic                    aclk,
    input  logic                    reset,

    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [31:0]             s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,

    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,

    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,

    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [31:0]             s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,

    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int unsigned StrbW     = DATA_WIDTH / 8;
    localparam int unsigned OffW      = $clog2(StrbW);
    localparam int unsigned IdxW      = $clog2(MEM_DEPTH);
    localparam logic [32:0] LimitAddr = {1'b0, BASE_ADDRESS} + 33'(MEM_DEPTH * StrbW);
    localparam logic [3:0]  DelayInit = 4'(RESP_DELAY);
    localparam logic [1:0]  RespOkay  = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    localparam logic [1:0] WrIdle  = 2'd0;
    localparam logic [1:0] WrDelay = 2'd1;
    localparam logic [1:0] WrData  = 2'd2;
    localparam logic [1:0] WrResp  = 2'd3;

    localparam logic [1:0] RdIdle  = 2'd0;
    localparam logic [1:0] RdDelay = 2'd1;
    localparam logic [1:0] RdData  = 2'd2;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx,
                                                 input logic [1:0]      burst);
        // FIXED holds the word; INCR, WRAP and reserved all step and wrap at the array end
        return (burst == 2'b00) ? idx : idx + IdxW'(1);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Address decode
    logic [31:0]     aw_off;
    logic [31:0]     ar_off;
    logic            aw_oor;
    logic            ar_oor;
    logic [IdxW-1:0] aw_idx;
    logic [IdxW-1:0] ar_idx;

    assign aw_off = s_axi_awaddr - BASE_ADDRESS;
    assign ar_off = s_axi_araddr - BASE_ADDRESS;
    assign aw_oor = (s_axi_awaddr < BASE_ADDRESS) || ({1'b0, s_axi_awaddr} >= LimitAddr);
    assign ar_oor = (s_axi_araddr < BASE_ADDRESS) || ({1'b0, s_axi_araddr} >= LimitAddr);
    assign aw_idx = aw_off[OffW +: IdxW];
    assign ar_idx = ar_off[OffW +: IdxW];

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_awqos, aw_off, ar_off};

    // Write engine state
    logic [1:0]          w_state_q, w_state_d;
    logic [3:0]          w_cnt_q, w_cnt_d;
    logic [7:0]          w_beat_q, w_beat_d;
    logic [7:0]          w_len_q, w_len_d;
    logic [1:0]          w_burst_q, w_burst_d;
    logic [IdxW-1:0]     w_idx_q, w_idx_d;
    logic [ID_WIDTH-1:0] w_id_q, w_id_d;
    logic                w_oor_q, w_oor_d;
    logic                w_err_q, w_err_d;
    logic                awready_q, awready_d;
    logic                w_mem_we;

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        w_beat_d  = w_beat_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_idx_d   = w_idx_q;
        w_id_d    = w_id_q;
        w_oor_d   = w_oor_q;
        w_err_d   = w_err_q;
        w_mem_we  = 1'b0;
        unique case (w_state_q)
            WrIdle: begin
                if (s_axi_awvalid && awready_q) begin
                    w_state_d = WrDelay;
                    w_cnt_d   = DelayInit;
                    w_beat_d  = 8'd0;
                    w_len_d   = s_axi_awlen;
                    w_burst_d = s_axi_awburst;
                    w_idx_d   = aw_idx;
                    w_id_d    = s_axi_awid;
                    w_oor_d   = aw_oor;
                    w_err_d   = aw_oor;
                end
            end
            WrDelay: begin
                if (w_cnt_q == 4'd0) begin
                    w_state_d = WrData;
                end else begin
                    w_cnt_d = w_cnt_q - 4'd1;
                end
            end
            WrData: begin
                if (s_axi_wvalid) begin
                    w_mem_we = !w_oor_q;
                    // The beat counter alone ends the burst; a wrong wlast only flags an error
                    if (s_axi_wlast != (w_beat_q == w_len_q)) begin
                        w_err_d = 1'b1;
                    end
                    if (w_beat_q == w_len_q) begin
                        w_state_d = WrResp;
                    end else begin
                        w_beat_d = w_beat_q + 8'd1;
                        w_idx_d  = next_idx(w_idx_q, w_burst_q);
                    end
                end
            end
            WrResp: begin
                if (s_axi_bready) begin
                    w_state_d = WrIdle;
                end
            end
            default: w_state_d = WrIdle;
        endcase
        awready_d = (w_state_d == WrIdle);
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            w_state_q <= WrIdle;
            w_cnt_q   <= 4'd0;
            w_beat_q  <= 8'd0;
            w_len_q   <= 8'd0;
            w_burst_q <= 2'b00;
            w_idx_q   <= '0;
            w_id_q    <= '0;
            w_oor_q   <= 1'b0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            w_beat_q  <= w_beat_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_idx_q   <= w_idx_d;
            w_id_q    <= w_id_d;
            w_oor_q   <= w_oor_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
        end
    end

    // Read engine state
    logic [1:0]          r_state_q, r_state_d;
    logic [3:0]          r_cnt_q, r_cnt_d;
    logic [7:0]          r_beat_q, r_beat_d;
    logic [7:0]          r_len_q, r_len_d;
    logic [1:0]          r_burst_q, r_burst_d;
    logic [IdxW-1:0]     r_idx_q, r_idx_d;
    logic [ID_WIDTH-1:0] r_id_q, r_id_d;
    logic                r_oor_q, r_oor_d;
    logic                arready_q, arready_d;
    logic                r_load;
    logic [IdxW-1:0]     r_addr;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_beat_d  = r_beat_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_idx_d   = r_idx_q;
        r_id_d    = r_id_q;
        r_oor_d   = r_oor_q;
        r_load    = 1'b0;
        r_addr    = r_idx_q;
        unique case (r_state_q)
            RdIdle: begin
                if (s_axi_arvalid && arready_q) begin
                    r_state_d = RdDelay;
                    r_cnt_d   = DelayInit;
                    r_beat_d  = 8'd0;
                    r_len_d   = s_axi_arlen;
                    r_burst_d = s_axi_arburst;
                    r_idx_d   = ar_idx;
                    r_id_d    = s_axi_arid;
                    r_oor_d   = ar_oor;
                end
            end
            RdDelay: begin
                if (r_cnt_q == 4'd0) begin
                    r_state_d = RdData;
                    r_load    = 1'b1;
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            RdData: begin
                if (s_axi_rready) begin
                    if (r_beat_q == r_len_q) begin
                        r_state_d = RdIdle;
                    end else begin
                        // Fetch the following beat on the accepting edge so beats stream back to back
                        r_beat_d = r_beat_q + 8'd1;
                        r_idx_d  = next_idx(r_idx_q, r_burst_q);
                        r_addr   = r_idx_d;
                        r_load   = 1'b1;
                    end
                end
            end
            default: r_state_d = RdIdle;
        endcase
        arready_d = (r_state_d == RdIdle);
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state_q <= RdIdle;
            r_cnt_q   <= 4'd0;
            r_beat_q  <= 8'd0;
            r_len_q   <= 8'd0;
            r_burst_q <= 2'b00;
            r_idx_q   <= '0;
            r_id_q    <= '0;
            r_oor_q   <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_beat_q  <= r_beat_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_idx_q   <= r_idx_d;
            r_id_q    <= r_id_d;
            r_oor_q   <= r_oor_d;
            arready_q <= arready_d;
        end
    end

    // Array contents survive reset; only in-flight beats are dropped
    always_ff @(posedge aclk) begin
        if (!reset && w_mem_we) begin
            for (int i = 0; i < StrbW; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem[w_idx_q][8*i +: 8] <= s_axi_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (r_load) begin
            rdata_q <= r_oor_q ? '0 : mem[r_addr];
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = (w_state_q == WrData);
    assign s_axi_bvalid  = (w_state_q == WrResp);
    assign s_axi_bid     = w_id_q;
    assign s_axi_bresp   = (s_axi_bvalid && w_err_q) ? RespSlvErr : RespOkay;

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = (r_state_q == RdData);
    assign s_axi_rid     = r_id_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = (s_axi_rvalid && r_oor_q) ? RespSlvErr : RespOkay;
    assign s_axi_rlast   = s_axi_rvalid && (r_beat_q == r_len_q);

endmodule
